multi_track_sequencer: RTL
==========================

// Module: multi_track_sequencer
// PURPOSE
//   Parametrised multi-track key sequencer for the keyboard sampler. Sits between
//   keyboard_tracker (held-key levels) and the tone/LED output stage. Modes:
//   - live: passes the pressed key through.
//   - record: samples keys into one of NUM_TRACKS tracks on a fixed step period.
//   - play: replays a track once or looped.
//   Live keys override playback.
// PARAMETERS
//   NUM_KEYS   9           number of key inputs; key bit k maps to code k+1
//   NUM_TRACKS 2           number of independent tracks, >=1
//   DEPTH      16          steps per track, >=1
//   STEP_TICKS 12_500_000  clock cycles per step (0.25 s at 50 MHz), >=2
//   Derived: CODE_W=$clog2(NUM_KEYS+1), TRK_W=max(1,$clog2(NUM_TRACKS)), LEN_W=$clog2(DEPTH+1)
// PORTS
//   clock      in   1       system clock (CLOCK_50)
//   resetn     in   1       asynchronous, active-low reset
//   keys       in   NUM_KEYS held-key levels from keyboard_tracker
//   mode       in   2       00 live, 01 record, 10 play, 11 clear
//   track_sel  in   TRK_W   target track, latched on mode entry
//   loop       in   1       play: 1 = wrap to step 0 at end
//   out_code   out  CODE_W  registered note code, 0 = silence
//   step_pulse out  1       1-cycle pulse on every record/play step
//   done       out  1       1-cycle pulse when a non-looped play finishes
//   busy       out  1       1 while in REC or PLAY
//   rec_full   out  1       1 while in REC and the track length equals DEPTH
//   track_len  out  LEN_W   stored length of the track selected by track_sel
// BEHAVIOUR
//   Reset (async, resetn=0):
//   - all outputs are 0; state is LIVE; all track lengths, tick_cnt and ptr are 0.
//   - Track memory contents are not reset.
//   Key decode:
//   - exactly one keys bit k set -> code k+1.
//   - zero bits or more than one bit set -> 0 (silence/rest).
//   FSM states: LIVE, REC, PLAY, HOLD. mode is evaluated every cycle.
//   - Any state, mode=00 -> LIVE. out_code <= decode(keys), 1-cycle latency.
//   - mode=11 -> len[track_sel] <= 0 every cycle mode=11 is held; state LIVE; out_code <= 0.
//   - Entry into REC (mode changes to 01):
//       trk <= track_sel; len[trk] <= 0 (overwrite); tick_cnt <= 0.
//   - Entry into PLAY (mode changes to 10):
//       trk <= track_sel; ptr <= 0; tick_cnt <= 0.
//   - Changes to track_sel are ignored while in REC, PLAY or HOLD.
//   Step timing:
//   - In REC/PLAY a step fires when tick_cnt==0. The first step fires on the first
//     cycle in the state.
//   - tick_cnt counts 0..STEP_TICKS-1 and wraps. step_pulse is registered with the step.
//   REC step:
//   - if len<DEPTH: mem[trk][len] <= decode(keys); len <= len+1. Rests are stored.
//   - if len==DEPTH: nothing is written and no step_pulse is issued; rec_full=1.
//   - State stays REC until mode changes. out_code follows live keys throughout.
//   PLAY step:
//   - if ptr<len[trk]: out_code <= mem[trk][ptr]; ptr <= ptr+1.
//   - if ptr==len[trk] and loop=1 and len>0: output mem[trk][0]; ptr <= 1.
//   - if ptr==len[trk] otherwise: done pulse; out_code <= 0; state -> HOLD.
//   - Empty track: done fires on the entry cycle's step.
//   - Between steps out_code holds the last step value.
//   - Live override: a nonzero decode(keys) replaces out_code on the next cycle.
//     The pointer and timing are unaffected.
//   HOLD:
//   - out_code follows live keys; no steps fire.
//   - Leave HOLD only via a mode change. Re-entering 10 restarts play from step 0.
//   Simultaneous events:
//   - Reset wins over everything.
//   - A mode change on a step cycle takes the new state; the old step is discarded.
//   - Leaving REC mid-way keeps the partial len.
//   - Clear of the track currently in PLAY cannot occur (mode can be only one value).
//   busy=1 in REC/PLAY. track_len is combinational from len[track_sel].
// TESTING  (bench: STEP_TICKS=4, DEPTH=4, NUM_TRACKS=2, NUM_KEYS=9)
//   1. Assert resetn=0 mid-operation -> all outputs 0 immediately; track_len=0 for both
//      tracks after release.
//   2. Live: keys=9'h004 -> out_code=3 next cycle; keys=9'h006 -> 0; keys=0 -> 0.
//   3. Record track 0 with keys 9'h001, 9'h002, 0, 9'h008 held across successive 4-cycle
//      steps -> track_len=4 and rec_full=1 after the 4th step; a 5th step gives no
//      step_pulse and no write.
//   4. Play track 0, loop=0 -> out_code 1,2,0,4, changing every 4 cycles; then done=1
//      for one cycle at step 5, out_code=0, busy=0, state HOLD.
//   5. Play track 0, loop=1 -> out_code 1,2,0,4,1,2,... and done never asserts.
//      Pressing keys=9'h100 mid-play -> out_code=9 next cycle while the pointer advances.
//   6. Record 2 steps to track 1, clear track 1, then play track 1 -> track_len
//      goes 2 -> 0; done fires on the entry cycle; track 0 is unchanged (track_len=4).

Source files
------------

// File: rtl/multi_track_sequencer.sv
// Multi-track key sequencer: live pass-through, step recording into
// per-track memories and once/looped playback with live key override.
module multi_track_sequencer #(
   parameter  int NUM_KEYS   = 9,
   parameter  int NUM_TRACKS = 2,
   parameter  int DEPTH      = 16,
   parameter  int STEP_TICKS = 12_500_000,
   localparam int CODE_W     = $clog2(NUM_KEYS + 1),
   localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
   localparam int LEN_W      = $clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic [1:0]          mode,
   input  logic [TRK_W-1:0]    track_sel,
   input  logic                loop,
   output logic [CODE_W-1:0]   out_code,
   output logic                step_pulse,
   output logic                done,
   output logic                busy,
   output logic                rec_full,
   output logic [LEN_W-1:0]    track_len
);

   localparam int ADR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TICK_W = $clog2(STEP_TICKS);
   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

   typedef enum logic [1:0] {
      S_LIVE,
      S_REC,
      S_PLAY,
      S_HOLD
   } state_e;

   state_e            state_q;
   logic [TRK_W-1:0]  trk_q;
   logic [LEN_W-1:0]  ptr_q, ptr_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [CODE_W-1:0] out_q, play_q, play_d, dec;
   logic              step_q, done_q, end_d;
   logic [LEN_W-1:0]  len_q [NUM_TRACKS];
   logic [CODE_W-1:0] mem_q [NUM_TRACKS][DEPTH];
   logic [LEN_W-1:0]  len_cur;
   logic              tick0, in_rec, rec_wr;

   // Chords and silence both decode to the rest code 0.
   always_comb begin
      dec = '0;
      if ($onehot(keys)) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) dec = CODE_W'(k + 1);
         end
      end
   end

   assign len_cur = len_q[trk_q];
   assign tick0   = (tick_q == '0);
   assign tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
   assign in_rec  = (mode == 2'b01) && (state_q == S_REC);
   assign rec_wr  = in_rec && tick0 && (len_cur < LEN_MAX);

   always_comb begin
      play_d = play_q;
      ptr_d  = ptr_q;
      end_d  = 1'b0;
      if (tick0) begin
         if (ptr_q < len_cur) begin
            play_d = mem_q[trk_q][ADR_W'(ptr_q)];
            ptr_d  = ptr_q + LEN_W'(1);
         end else if (loop && (len_cur != '0)) begin
            play_d = mem_q[trk_q][0];
            ptr_d  = LEN_W'(1);
         end else begin
            play_d = '0;
            end_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rec_wr) mem_q[trk_q][ADR_W'(len_cur)] <= dec;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_LIVE;
         trk_q   <= '0;
         ptr_q   <= '0;
         tick_q  <= '0;
         out_q   <= '0;
         play_q  <= '0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int t = 0; t < NUM_TRACKS; t++) len_q[t] <= '0;
      end else begin
         step_q <= 1'b0;
         done_q <= 1'b0;
         unique case (mode)
            2'b00: begin
               state_q <= S_LIVE;
               out_q   <= dec;
            end
            2'b11: begin
               state_q          <= S_LIVE;
               out_q            <= '0;
               len_q[track_sel] <= '0;
            end
            2'b01: begin
               out_q <= dec;
               if (state_q != S_REC) begin
                  state_q          <= S_REC;
                  trk_q            <= track_sel;
                  tick_q           <= '0;
                  len_q[track_sel] <= '0;
               end else begin
                  tick_q <= tick_d;
                  if (rec_wr) begin
                     len_q[trk_q] <= len_cur + LEN_W'(1);
                     step_q       <= 1'b1;
                  end
               end
            end
            2'b10: begin
               if (state_q == S_HOLD) begin
                  out_q <= dec;
               end else if (state_q != S_PLAY) begin
                  state_q <= S_PLAY;
                  trk_q   <= track_sel;
                  ptr_q   <= '0;
                  tick_q  <= '0;
                  play_q  <= '0;
                  out_q   <= dec;
               end else begin
                  // play_q keeps the step value so a released key restores it
                  tick_q <= tick_d;
                  ptr_q  <= ptr_d;
                  play_q <= play_d;
                  out_q  <= (dec != '0) ? dec : play_d;
                  step_q <= tick0;
                  if (end_d) begin
                     done_q  <= 1'b1;
                     state_q <= S_HOLD;
                  end
               end
            end
         endcase
      end
   end

   assign out_code   = out_q;
   assign step_pulse = step_q;
   assign done       = done_q;
   assign busy       = (state_q == S_REC) || (state_q == S_PLAY);
   assign rec_full   = (state_q == S_REC) && (len_cur == LEN_MAX);
   assign track_len  = len_q[track_sel];

endmodule
